if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 86 ++++++++
 1 files changed

// File: rtl/if_stage.sv
// if_stage: instruction fetch with hold buffer, wait-state tracking and drain-on-redirect.
module if_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_enable,
    input  logic        if_id_enable,
    input  logic        branch_taken_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic        fetch_stall
);
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic [1:0] {BOOT, RUN, DRAIN} state_t;
    state_t      state, state_next;
    logic [31:0] pc, redirect_pc, hold_inst, hold_pc, target;
    logic        hold_valid, req_pending, fetch_done;

    assign target = branch_target & ~32'h3;
    assign imem_addr = pc;

    always_comb begin
        imem_req = (state == DRAIN) || (state == RUN && !hold_valid && (pc_enable || req_pending));
        fetch_done = imem_req && imem_ready;
        fetch_stall = imem_req && !imem_ready;
        state_next = state;
        if (state == BOOT)
            state_next = RUN;
        else if (branch_taken_flag)
            state_next = fetch_stall ? DRAIN : RUN;
        else if (state == DRAIN && fetch_done)
            state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= BOOT;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            redirect_pc <= '0;
            hold_inst   <= NOP;
            hold_pc     <= '0;
            hold_valid  <= 1'b0;
            req_pending <= 1'b0;
            if_id_pc    <= '0;
            if_id_inst  <= NOP;
            if_id_valid <= 1'b0;
        end else if (state != BOOT) begin
            req_pending <= fetch_stall;
            if (branch_taken_flag) begin
                // An incomplete fetch must finish at its old address before the redirect applies
                if_id_inst  <= NOP;
                if_id_valid <= 1'b0;
                hold_valid  <= 1'b0;
                if (fetch_stall) redirect_pc <= target;
                else             pc <= target;
            end else if (state == DRAIN) begin
                if (fetch_done) pc <= redirect_pc;
                if (if_id_enable) begin
                    if_id_inst  <= NOP;
                    if_id_valid <= 1'b0;
                end
            end else begin
                if (fetch_done) pc <= pc + 32'd4;
                if (if_id_enable) begin
                    if_id_pc    <= hold_valid ? hold_pc : fetch_done ? pc : if_id_pc;
                    if_id_inst  <= hold_valid ? hold_inst : fetch_done ? imem_rdata : NOP;
                    if_id_valid <= hold_valid || fetch_done;
                    hold_valid  <= 1'b0;
                end else if (fetch_done) begin
                    hold_inst  <= imem_rdata;
                    hold_pc    <= pc;
                    hold_valid <= 1'b1;
                end
            end
        end
    end
endmodule
